// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM states and default widths for the UART TX arbiter.
package uart_arb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational winner select; round-robin from last+1, or lowest index under UART_ARB_FIXED_PRIO_EN.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);
`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  always_comb begin
    winner = '0;
    valid  = |req;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) winner = ID_W'(i);
  end
`else
  logic [ID_W-1:0] idx;
  // Scan downward so the closest candidate after last is the final assignment.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(last) + i) % N_REQ);
      if (req[idx]) winner = idx;
    end
  end
`endif
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ byte sources; UART_ARB_FIXED_PRIO_EN selects fixed priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);
  arb_state_t        state, state_n;
  logic [ID_W-1:0]   pick_id, grant_n;
  logic              pick_valid, launch;
  logic [N_REQ-1:0]  ack_n;
  logic [DATA_W-1:0] tx_data_n;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (req),
    .last   (grant_id),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_comb begin
    launch    = (state == IDLE) && pick_valid && !tx_busy;
    ack_n     = launch ? (N_REQ'(1) << pick_id) : '0;
    tx_data_n = launch ? req_data[pick_id*DATA_W +: DATA_W] : tx_data;
    grant_n   = launch ? pick_id : grant_id;
    case (state)
      IDLE:      state_n = launch ? LAUNCH : IDLE;
      LAUNCH:    state_n = tx_done ? IDLE : WAIT_DONE;
      WAIT_DONE: state_n = tx_done ? IDLE : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      start    <= 1'b0;
      ack      <= '0;
      tx_data  <= '0;
      grant_id <= ID_W'(N_REQ - 1);
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      start    <= launch;
      ack      <= ack_n;
      tx_data  <= tx_data_n;
      grant_id <= grant_n;
      busy     <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter; honours UART_ARB_FIXED_PRIO_EN.
module tb_uart_tx_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    tx_done;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .start    (start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start && n < 20) begin
      tick();
      n++;
    end
    check({tag, " start seen"}, 32'(start), 32'd1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    logic [ID_W-1:0] exp_id;
    reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    #1;
    check("rst start", 32'(start), 32'd0);
    check("rst ack", 32'(ack), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst grant_id", 32'(grant_id), 32'd3);
    check("rst busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;

    req = 4'b0001; req_data[7:0] = 8'h41;
    tick();
    check("t1 start", 32'(start), 32'd1);
    check("t1 ack", 32'(ack), 32'b0001);
    check("t1 tx_data", 32'(tx_data), 32'h41);
    check("t1 grant_id", 32'(grant_id), 32'd0);
    check("t1 busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    check("t1 start drop", 32'(start), 32'd0);
    check("t1 ack drop", 32'(ack), 32'd0);
    tick(); tick(); tick();
    check("t1 hold busy", 32'(busy), 32'd1);
    check("t1 hold data", 32'(tx_data), 32'h41);
    pulse_done();
    check("t1 idle busy", 32'(busy), 32'd0);
    tick();
    check("t1 no relaunch", 32'(start), 32'd0);

    do_reset();
    req = 4'b1111; req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    for (int i = 0; i < 8; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      exp_id = '0;
`else
      exp_id = ID_W'(i % N_REQ);
`endif
      wait_start($sformatf("rr%0d", i));
      check($sformatf("rr%0d grant", i), 32'(grant_id), 32'(exp_id));
      check($sformatf("rr%0d data", i), 32'(tx_data), 32'h30 + 32'(exp_id));
      check($sformatf("rr%0d ack", i), 32'(ack), 32'(4'b0001 << exp_id));
      for (int j = 0; j < 9; j++) tick();
      pulse_done();
    end

    req = 4'b0100; tx_busy = 1'b1;
    tick(); tick(); tick();
    check("busy hold start", 32'(start), 32'd0);
    check("busy hold ack", 32'(ack), 32'd0);
    check("busy hold busy", 32'(busy), 32'd0);
    tx_busy = 1'b0;
    tick();
    check("busy rel start", 32'(start), 32'd1);
    check("busy rel ack", 32'(ack), 32'b0100);
    check("busy rel grant", 32'(grant_id), 32'd2);
    req = '0;
    tick();
    pulse_done();

    req = 4'b0001; req_data[7:0] = 8'h5A;
    tick();
    check("abort launch", 32'(start), 32'd1);
    req = '0;
    tick(); tick();
    check("abort wait data", 32'(tx_data), 32'h5A);
    check("abort wait busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort start", 32'(start), 32'd0);
    check("abort ack", 32'(ack), 32'd0);
    check("abort tx_data", 32'(tx_data), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort grant", 32'(grant_id), 32'd3);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("abort no relaunch", 32'(start), 32'd0);
    check("abort idle", 32'(busy), 32'd0);

    req = 4'b0010;
    tick();
    check("early first start", 32'(start), 32'd1);
    check("early first grant", 32'(grant_id), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("early idle busy", 32'(busy), 32'd0);
    check("early gap start", 32'(start), 32'd0);
    tick();
    check("early second start", 32'(start), 32'd1);
    check("early second grant", 32'(grant_id), 32'd1);
    check("early second ack", 32'(ack), 32'b0010);
    req = '0;
    tick();
    pulse_done();
    check("final idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
